sr_store: RTL and testbench
===========================

Name: sr_store

Overview:
- Clocked storage stage directly downstream of the SR input-conditioning logic.
- Consumes the conditioned set/reset pair and holds the resulting bit in a synchronous register.
- Detects set/reset conflicts and latches a fault after a run of them.
- Keeps a count of set events and a short history of the stored bit for readout on the output pins.

Parameters:
- SYNC_STAGES, 2, input synchronizer depth on s_in/r_in; legal 0..3; 0 = sample directly.
- CONFLICT_LIMIT, 4, consecutive conflict cycles (s=r=1) that force FAULT; legal 1..15.
- COUNT_W, 4, width of the saturating set-event counter.
- HIST_W, 4, width of the q history shift register.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset; deassertion is synchronous to clk.
- ena, input, 1, clock enable; when 0, all state holds, synchronizer included.
- s_in, input, 1, conditioned set request (from s_setup).
- r_in, input, 1, conditioned reset request (from r_setup).
- clr, input, 1, synchronous clear of fault, conflict, counter and history; q is not cleared.
- q, output, 1, stored bit.
- q_n, output, 1, ~q, always exact complement.
- fault, output, 1, high while the state machine is in FAULT.
- conflict, output, 1, sticky flag: at least one s=r=1 cycle seen since reset or clr.
- set_count, output, COUNT_W, number of q 0->1 transitions, saturating.
- hist, output, HIST_W, last HIST_W values of q; bit 0 is newest.

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following are cleared at once:
  - state=HOLD0, q=0, q_n=1, fault=0, conflict=0
  - set_count=0, hist=0, synchronizer flops=0, conflict run counter=0
- Synchronizer:
  - s_in/r_in each pass through SYNC_STAGES flops. The synchronized pair is ss/rs.
  - With SYNC_STAGES=N, an input change is first visible on q at the (N+1)th enabled edge after the change.
- State machine, evaluated on each enabled edge using ss/rs:
  - HOLD0 (q=0):
    - ss=1, rs=0 -> HOLD1.
    - ss=0, rs=1, or ss=0, rs=0 -> stay.
    - ss=1, rs=1 -> stay; increment the run counter.
  - HOLD1 (q=1):
    - ss=0, rs=1 -> HOLD0.
    - ss=1, rs=0, or ss=0, rs=0 -> stay.
    - ss=1, rs=1 -> stay; increment the run counter.
  - Run counter: resets to 0 on any non-conflict cycle. When it would reach CONFLICT_LIMIT, go to FAULT instead.
  - FAULT: q forced to 0, fault=1. Exit only on clr=1, to HOLD0, with the run counter cleared. s/r are ignored while in FAULT.
- conflict: set on any enabled edge with ss=rs=1, including while in FAULT. Cleared only by clr or reset.
- set_count: +1 on each edge where q goes 0->1. Holds at 2^COUNT_W-1; no wrap.
- hist: on each enabled edge, hist <= {hist[HIST_W-2:0], q_next}. q_next is the value q takes at that edge.
- clr priority:
  - Same edge as ss=1, rs=0 in HOLD0: clr wins for fault/conflict/set_count/hist; the state transition still happens. set_count becomes 0, not 1; hist becomes {0..,1}.
  - Same edge as a conflict cycle: conflict is cleared and the run counter restarts at 0.
- ena=0: no state, counter, history or synchronizer change. clr is also ignored.
- rst_n asserted mid-run, or mid-FAULT: immediate return to the reset values listed above. No partial state survives.
- All outputs are registered, except q_n, which is the inverter of q.

Decomposition:
- Shared package sr_pkg holds:
  - state enumeration: HOLD0=2'd0, HOLD1=2'd1, FAULT=2'd2.
  - default constants SYNC_STAGES_DEF, CONFLICT_LIMIT_DEF.
- Sub-module: sync_chain (parameterised depth, width 2, async active-low reset, ena). Reusable for other pin inputs.
- FSM, run counter, set counter and history stay in sr_store.

Test Plan (SYNC_STAGES=2, CONFLICT_LIMIT=4, COUNT_W=4, HIST_W=4, ena=1 unless stated):
- Reset then s_in=1 pulse for 1 cycle -> q=1 at the 3rd edge after the pulse; set_count=1; hist=4'b0001; q_n=0.
- Toggle s_in/r_in for 20 set pulses, each followed by a reset pulse -> set_count saturates at 15 and stays 15; conflict=0.
- s_in=r_in=1 for 3 cycles, then r_in=0 -> conflict=1, fault=0, q=1 (HOLD1 reached after release).
- s_in=r_in=1 for 4 cycles -> fault=1, q=0; further s_in pulses have no effect; clr pulse -> fault=0, conflict=0, set_count=0, hist=0; the next s_in pulse sets q=1.
- ena=0 with s_in=1 held for 10 cycles -> q, set_count and hist unchanged; raise ena -> q=1 after 3 enabled edges.
- rst_n driven low asynchronously mid-FAULT (between clock edges) -> all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared types and defaults for the SR storage stage and its helpers.
package sr_pkg;

    typedef enum logic [1:0] {
        HOLD0 = 2'd0,
        HOLD1 = 2'd1,
        FAULT = 2'd2
    } sr_state_e;

    // Set/reset pair as carried through the input synchronizer
    typedef struct packed {
        logic s;
        logic r;
    } sr_pair_t;

    localparam int unsigned SYNC_STAGES_DEF    = 2;
    localparam int unsigned CONFLICT_LIMIT_DEF = 4;
    localparam int unsigned COUNT_W_DEF        = 4;
    localparam int unsigned HIST_W_DEF         = 4;

endpackage

// File: rtl/sr_store_if.sv
// Pin bundle between the SR conditioning logic / readout and sr_store.
interface sr_store_if #(
    parameter int unsigned COUNT_W = 4,
    parameter int unsigned HIST_W  = 4
);
    logic               ena;
    logic               s_in;
    logic               r_in;
    logic               clr;
    logic               q;
    logic               q_n;
    logic               fault;
    logic               conflict;
    logic [COUNT_W-1:0] set_count;
    logic [HIST_W-1:0]  hist;

    modport master (
        output ena, s_in, r_in, clr,
        input  q, q_n, fault, conflict, set_count, hist
    );

    modport slave (
        input  ena, s_in, r_in, clr,
        output q, q_n, fault, conflict, set_count, hist
    );
endinterface

// File: rtl/sync_chain.sv
// Enabled flop chain for pin inputs; DEPTH=0 passes the input straight through.
module sync_chain #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH == 0) begin : g_bypass
        assign q = d;
    end else begin : g_chain
        logic [WIDTH-1:0] stage [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
            end else if (ena) begin
                stage[0] <= d;
                for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end
endmodule

// File: rtl/sr_store.sv
// Synchronous SR storage bit with conflict-run fault detection,
// saturating set-event counter and a short history of the stored bit.
module sr_store
    import sr_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int unsigned CONFLICT_LIMIT = CONFLICT_LIMIT_DEF,
    parameter int unsigned COUNT_W        = COUNT_W_DEF,
    parameter int unsigned HIST_W         = HIST_W_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    sr_store_if.slave bus
);
    localparam int unsigned RUN_W = $clog2(CONFLICT_LIMIT + 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    sr_pair_t pair_in;
    sr_pair_t pair_sync;

    sr_state_e          state,       state_next;
    logic [RUN_W-1:0]   run_cnt,     run_next;
    logic               q_r,         q_next;
    logic               fault_r;
    logic               conflict_r,  conflict_next;
    logic [COUNT_W-1:0] set_count_r, set_count_next;
    logic [HIST_W-1:0]  hist_r,      hist_next;
    logic               both;

    assign pair_in = sr_pair_t'({bus.s_in, bus.r_in});

    sync_chain #(
        .DEPTH (SYNC_STAGES),
        .WIDTH ($bits(sr_pair_t))
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (bus.ena),
        .d     (pair_in),
        .q     (pair_sync)
    );

    assign both = pair_sync.s & pair_sync.r;

    // Next-state and next-output logic
    always_comb begin
        state_next     = state;
        run_next       = run_cnt;
        conflict_next  = conflict_r;
        set_count_next = set_count_r;

        case (state)
            HOLD0, HOLD1: begin
                if (both && !bus.clr) begin
                    // A clr on a conflict edge restarts the run instead of extending it
                    if (run_cnt == RUN_W'(CONFLICT_LIMIT - 1)) begin
                        state_next = FAULT;
                        run_next   = '0;
                    end else begin
                        run_next = run_cnt + RUN_W'(1);
                    end
                end else begin
                    run_next = '0;
                    if (pair_sync.s && !pair_sync.r)      state_next = HOLD1;
                    else if (pair_sync.r && !pair_sync.s) state_next = HOLD0;
                end
            end
            FAULT: begin
                run_next = '0;
                if (bus.clr) state_next = HOLD0;
            end
            default: begin
                state_next = HOLD0;
                run_next   = '0;
            end
        endcase

        q_next    = (state_next == HOLD1);
        hist_next = {hist_r[HIST_W-2:0], q_next};

        if (both) conflict_next = 1'b1;
        if (q_next && !q_r && (set_count_r != COUNT_MAX))
            set_count_next = set_count_r + COUNT_W'(1);

        // clr wins over flags and counters; the state transition itself still happens
        if (bus.clr) begin
            conflict_next  = 1'b0;
            set_count_next = '0;
            hist_next      = HIST_W'(q_next);
            run_next       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HOLD0;
            run_cnt     <= '0;
            q_r         <= 1'b0;
            fault_r     <= 1'b0;
            conflict_r  <= 1'b0;
            set_count_r <= '0;
            hist_r      <= '0;
        end else if (bus.ena) begin
            state       <= state_next;
            run_cnt     <= run_next;
            q_r         <= q_next;
            fault_r     <= (state_next == FAULT);
            conflict_r  <= conflict_next;
            set_count_r <= set_count_next;
            hist_r      <= hist_next;
        end
    end

    assign bus.q         = q_r;
    assign bus.q_n       = ~q_r;
    assign bus.fault     = fault_r;
    assign bus.conflict  = conflict_r;
    assign bus.set_count = set_count_r;
    assign bus.hist      = hist_r;

endmodule

// File: tb/tb_sr_store.sv
// Directed and random stimulus for sr_store, checked against a cycle-level
// behavioural model of the stored bit, fault, flags, counter and history.
module tb_sr_store;
    localparam int N       = 2;
    localparam int LIMIT   = 4;
    localparam int CNT_MAX = 15;
    localparam int HMASK   = 15;

    logic clk;
    logic rst_n;

    sr_store_if #(.COUNT_W(4), .HIST_W(4)) bus ();

    sr_store #(
        .SYNC_STAGES    (N),
        .CONFLICT_LIMIT (LIMIT),
        .COUNT_W        (4),
        .HIST_W         (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: input delay line plus the architectural state
    bit dl_s [N];
    bit dl_r [N];
    bit m_q, m_fault, m_conf;
    int m_run, m_cnt, m_hist;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            dl_s[i] = 1'b0;
            dl_r[i] = 1'b0;
        end
        m_q = 0; m_fault = 0; m_conf = 0;
        m_run = 0; m_cnt = 0; m_hist = 0;
    endtask

    task automatic model_edge();
        bit ss, rs, qn;
        if (!bus.ena) return;
        ss = dl_s[N-1];
        rs = dl_r[N-1];
        for (int i = N - 1; i > 0; i--) begin
            dl_s[i] = dl_s[i-1];
            dl_r[i] = dl_r[i-1];
        end
        dl_s[0] = bus.s_in;
        dl_r[0] = bus.r_in;
        qn = m_q;
        if (m_fault) begin
            if (bus.clr) m_fault = 0;
        end else if (ss && rs && !bus.clr) begin
            m_run++;
            if (m_run >= LIMIT) begin
                m_fault = 1;
                qn = 0;
                m_run = 0;
            end
        end else begin
            m_run = 0;
            if (ss && !rs) qn = 1;
            else if (rs && !ss) qn = 0;
        end
        if (bus.clr) begin
            m_conf = 0;
            m_cnt  = 0;
            m_hist = int'(qn);
        end else begin
            if (ss && rs) m_conf = 1;
            if (qn && !m_q && m_cnt < CNT_MAX) m_cnt++;
            m_hist = ((m_hist << 1) | int'(qn)) & HMASK;
        end
        m_q = qn;
    endtask

    task automatic check_all();
        chk("q",         32'(bus.q),         32'(m_q));
        chk("q_n",       32'(bus.q_n),       32'(!m_q));
        chk("fault",     32'(bus.fault),     32'(m_fault));
        chk("conflict",  32'(bus.conflict),  32'(m_conf));
        chk("set_count", 32'(bus.set_count), m_cnt);
        chk("hist",      32'(bus.hist),      m_hist);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int snap_cnt, snap_hist;
        rst_n = 1'b0;
        bus.ena = 1'b1; bus.s_in = 1'b0; bus.r_in = 1'b0; bus.clr = 1'b0;
        model_reset();
        #12;
        check_all();
        #10 rst_n = 1'b1;

        // Single set pulse: q rises on the third edge
        bus.s_in = 1'b1; tick();
        bus.s_in = 1'b0; tick();
        chk("q_before_3rd", 32'(bus.q), 32'd0);
        tick();
        chk("q_set", 32'(bus.q), 32'd1);
        chk("q_n_set", 32'(bus.q_n), 32'd0);
        chk("count_first", 32'(bus.set_count), 32'd1);
        chk("hist_first", 32'(bus.hist), 32'b0001);

        // Set/reset pulse train drives the counter into saturation
        for (int i = 0; i < 20; i++) begin
            bus.s_in = 1'b1; tick();
            bus.s_in = 1'b0; bus.r_in = 1'b1; tick();
            bus.r_in = 1'b0; tick();
        end
        ticks(3);
        chk("count_sat", 32'(bus.set_count), 32'd15);
        chk("conflict_none", 32'(bus.conflict), 32'd0);
        chk("q_after_train", 32'(bus.q), 32'd0);

        // Conflict run shorter than the limit, then set wins
        bus.s_in = 1'b1; bus.r_in = 1'b1; ticks(3);
        bus.r_in = 1'b0; ticks(4);
        bus.s_in = 1'b0; ticks(2);
        chk("short_run_conflict", 32'(bus.conflict), 32'd1);
        chk("short_run_fault", 32'(bus.fault), 32'd0);
        chk("short_run_q", 32'(bus.q), 32'd1);

        bus.clr = 1'b1; tick();
        bus.clr = 1'b0; tick();

        // Conflict run at the limit forces FAULT; set is ignored until clr
        bus.s_in = 1'b1; bus.r_in = 1'b1; ticks(4);
        bus.s_in = 1'b0; bus.r_in = 1'b0; ticks(3);
        chk("fault_entered", 32'(bus.fault), 32'd1);
        chk("fault_q", 32'(bus.q), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.s_in = 1'b1; tick();
            bus.s_in = 1'b0; tick();
        end
        ticks(3);
        chk("fault_held", 32'(bus.fault), 32'd1);
        chk("fault_q_held", 32'(bus.q), 32'd0);
        bus.clr = 1'b1; tick();
        bus.clr = 1'b0;
        chk("clr_fault", 32'(bus.fault), 32'd0);
        chk("clr_conflict", 32'(bus.conflict), 32'd0);
        chk("clr_count", 32'(bus.set_count), 32'd0);
        chk("clr_hist", 32'(bus.hist), 32'd0);
        bus.s_in = 1'b1; tick();
        bus.s_in = 1'b0; ticks(2);
        chk("set_after_clr", 32'(bus.q), 32'd1);
        chk("count_after_clr", 32'(bus.set_count), 32'd1);

        // Random traffic including ena gaps and occasional clr
        for (int i = 0; i < 400; i++) begin
            bus.s_in = ($urandom_range(0, 9) < 4);
            bus.r_in = ($urandom_range(0, 9) < 4);
            bus.clr  = ($urandom_range(0, 31) == 0);
            bus.ena  = ($urandom_range(0, 7) != 0);
            tick();
        end
        bus.ena = 1'b1; bus.clr = 1'b0; bus.s_in = 1'b0; bus.r_in = 1'b0;
        ticks(2);
        bus.clr = 1'b1; tick();
        bus.clr = 1'b0;
        bus.r_in = 1'b1; tick();
        bus.r_in = 1'b0; ticks(3);
        chk("pre_ena_q", 32'(bus.q), 32'd0);

        // ena low freezes everything, synchronizer included
        snap_cnt  = m_cnt;
        snap_hist = m_hist;
        bus.ena = 1'b0; bus.s_in = 1'b1;
        ticks(10);
        chk("ena_q", 32'(bus.q), 32'd0);
        chk("ena_count", 32'(bus.set_count), snap_cnt);
        chk("ena_hist", 32'(bus.hist), snap_hist);
        bus.ena = 1'b1;
        ticks(2);
        chk("ena_q_edge2", 32'(bus.q), 32'd0);
        tick();
        chk("ena_q_edge3", 32'(bus.q), 32'd1);
        bus.s_in = 1'b0; ticks(2);

        // Async reset in the middle of FAULT
        bus.s_in = 1'b1; bus.r_in = 1'b1; ticks(6);
        chk("fault_before_rst", 32'(bus.fault), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_q", 32'(bus.q), 32'd0);
        chk("rst_q_n", 32'(bus.q_n), 32'd1);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_conflict", 32'(bus.conflict), 32'd0);
        chk("rst_count", 32'(bus.set_count), 32'd0);
        chk("rst_hist", 32'(bus.hist), 32'd0);
        model_reset();
        bus.s_in = 1'b0; bus.r_in = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Short conflict run after reset must not fault: run counter was cleared
        bus.s_in = 1'b1; bus.r_in = 1'b1; ticks(3);
        bus.s_in = 1'b0; bus.r_in = 1'b0; ticks(3);
        chk("post_rst_fault", 32'(bus.fault), 32'd0);
        bus.s_in = 1'b1; tick();
        bus.s_in = 1'b0; ticks(2);
        chk("post_rst_set", 32'(bus.q), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
